muldiv_iter: RTL and testbench
==============================

MULDIV_ITER -- requirements
Module: muldiv_iter

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter BPC, default 1, quotient/multiplier bits retired per iteration; legal 1, 2, 4; XLEN % BPC == 0.
REQ-003 SHALL have parameter CACHE_EN, default 1, enables last-result reuse.
REQ-004 SHALL have port s_clk_i  input  1  clock; single clock domain.
REQ-005 SHALL have port s_resetn_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port s_stall_i  input  1  downstream (MA) stall; result held.
REQ-007 SHALL have port s_flush_i  input  1  pipeline flush; abort operation.
REQ-008 SHALL have port s_compute_i  input  1  EX holds an M-extension instruction.
REQ-009 SHALL have port s_op_i  input  3  RISC-V M funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-010 SHALL have ports s_operand1_i, s_operand2_i  input  XLEN  rs1, rs2.
REQ-011 SHALL have port s_finished_o  output  1  result valid this cycle.
REQ-012 SHALL have port s_result_o  output  XLEN  result; zero when s_finished_o=0.
REQ-013 SHALL have port s_busy_o  output  1  state != IDLE.

Function
REQ-014 SHALL implement FSM IDLE, CALC, DONE.
REQ-015 IDLE & s_compute_i & !s_flush_i: latch op/operands, take absolute values per signedness, go CALC (normal), or DONE (fast path).
REQ-016 Fast path: divisor==0 -> quotient all-ones, remainder = dividend; signed overflow (MIN / -1) -> quotient MIN, remainder 0; either operand 0 for MUL* -> 0; cache hit.
REQ-017 CALC: N = XLEN/BPC iterations, one per cycle; shift-add multiply (2*XLEN accumulator), restoring divide; iteration counter wraps never, exits at N-1 to DONE.
REQ-018 Normal latency: compute seen at cycle 0, s_finished_o=1 at cycle N+1; fast path at cycle 1.
REQ-019 Sign correction (negate product / quotient / remainder) applied when entering DONE; remainder sign follows dividend.
REQ-020 DONE: s_finished_o=1, s_result_o stable; stays DONE while s_stall_i=1; s_stall_i=0 -> IDLE (instruction retires).
REQ-021 s_flush_i in any state -> IDLE next cycle, s_finished_o=0 that cycle onward, no cache update from aborted op; flush has priority over compute and stall.
REQ-022 s_stall_i SHALL NOT freeze CALC iterations; only the DONE hand-off.
REQ-023 Cache (CACHE_EN=1): stores operands, signedness class, full 2*XLEN product or quotient+remainder, valid bit, updated on DONE entry from CALC.
REQ-024 Hit: valid & operands equal & same class (MUL/MULH* share product if signedness matches; DIV/REM pair share if signedness matches).
REQ-025 s_compute_i deasserted while CALC (no flush) SHALL be ignored; operation completes.
REQ-026 Back-to-back: new compute in cycle after DONE->IDLE accepted normally.

Reset
REQ-027 Reset SHALL force IDLE, clear counter, accumulators, cache valid; s_finished_o=0, s_result_o=0, s_busy_o=0.
REQ-028 Reset mid-CALC SHALL abort immediately; no result produced after release.

Structure
REQ-029 Op enum (funct3 values) and MDU state enum SHALL reside in p_hardisc.
REQ-030 One combinational sub-module muldiv_step (one BPC-bit multiply-add / restoring-divide step, XLEN param) SHALL be instantiated.
REQ-031 Result and finished outputs SHALL pass through see_wires (GROUP SEEGR_CORE_WIRE) as elsewhere in the core.

Verification
REQ-032 MUL 7 x -3, BPC=1 -> s_finished_o at cycle 33, result 0xFFFFFFEB.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> cycle 1, result 0x80000000; REM same -> 0.
REQ-034 DIVU 100 / 0 -> cycle 1, 0xFFFFFFFF; REMU 100 / 0 -> 100.
REQ-035 DIV -7/2 (cycle 33, 0xFFFFFFFD) then REM -7/2 -> cache hit, cycle 1, 0xFFFFFFFF.
REQ-036 MULHU 0xFFFFFFFF x 0xFFFFFFFF with s_flush_i at cycle 10 -> IDLE cycle 11, no finished; rerun -> 0xFFFFFFFE, no cache hit.
REQ-037 BPC=4, DIVU 1000/7 with s_stall_i held 3 cycles at DONE -> finished cycle 9, held 142 for 4 cycles, IDLE after.

Source files
------------

// File: rtl/p_hardisc.sv
// Shared core types: M-extension op encoding, MDU state, and SEE wire groups.
package p_hardisc;

    // RISC-V M-extension funct3 encoding
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state;

    // Groups for single-event-effect injection points on core wires
    localparam int SEEGR_NONE      = 0;
    localparam int SEEGR_CORE_WIRE = 1;

    // MUL is treated as signed x signed: its low word is identical for every
    // signedness, so this only narrows which cached products it may reuse.
    function automatic logic op1_signed(mdu_op op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op2_signed(mdu_op op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_is_div(mdu_op op);
        return op[2];
    endfunction

    // Result comes from the upper word (product high / remainder)
    function automatic logic op_sel_hi(mdu_op op);
        return op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the MDU: BPC-bit shift-add multiply or BPC restoring-divide steps.
module muldiv_step #(
    parameter int XLEN = 32,
    parameter int BPC  = 1
)(
    input  logic            s_div_i,
    input  logic [XLEN-1:0] s_hi_i,   // partial product / partial remainder
    input  logic [XLEN-1:0] s_lo_i,   // remaining multiplier / dividend->quotient
    input  logic [XLEN-1:0] s_b_i,    // multiplicand / divisor (magnitudes)
    output logic [XLEN-1:0] s_hi_o,
    output logic [XLEN-1:0] s_lo_o
);

    localparam int XB = XLEN + BPC;

    logic [XB-1:0]   sum;
    logic [XLEN-1:0] r, q;
    logic [XLEN:0]   t;

    // Multiply: add multiplicand x low BPC multiplier bits, shift {hi,lo} right.
    // Divide: BPC restoring steps, quotient bits shifted into lo.
    always_comb begin
        sum = XB'(s_hi_i) + XB'(s_b_i) * XB'(s_lo_i[BPC-1:0]);
        r   = s_hi_i;
        q   = s_lo_i;
        t   = '0;
        for (int i = 0; i < BPC; i++) begin
            t = {r, q[XLEN-1]};
            q = {q[XLEN-2:0], 1'b0};
            if (t >= {1'b0, s_b_i}) begin
                t    = t - {1'b0, s_b_i};
                q[0] = 1'b1;
            end
            r = t[XLEN-1:0];
        end
        if (s_div_i) begin
            s_hi_o = r;
            s_lo_o = q;
        end else begin
            s_hi_o = sum[XB-1:BPC];
            s_lo_o = {sum[BPC-1:0], s_lo_i[XLEN-1:BPC]};
        end
    end

endmodule

// File: rtl/see_wires.sv
// Named pass-through for core wires that fault-injection harnesses bind to by group.
module see_wires import p_hardisc::*; #(
    parameter int GROUP = SEEGR_NONE,
    parameter int W     = 1
)(
    input  logic [W-1:0] s_c_i,
    output logic [W-1:0] s_d_o
);

    // The named scope gives injection harnesses a stable handle per group
    if (GROUP == SEEGR_NONE) begin : g_plain
        assign s_d_o = s_c_i;
    end else begin : g_see
        assign s_d_o = s_c_i;
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RISC-V M-extension unit with fast paths and a last-result cache.
module muldiv_iter import p_hardisc::*; #(
    parameter int XLEN     = 32,
    parameter int BPC      = 1,
    parameter bit CACHE_EN = 1
)(
    input  logic            s_clk_i,
    input  logic            s_resetn_i,
    input  logic            s_stall_i,
    input  logic            s_flush_i,
    input  logic            s_compute_i,
    input  logic [2:0]      s_op_i,
    input  logic [XLEN-1:0] s_operand1_i,
    input  logic [XLEN-1:0] s_operand2_i,
    output logic            s_finished_o,
    output logic [XLEN-1:0] s_result_o,
    output logic            s_busy_o
);

    localparam int N     = XLEN / BPC;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state state_q, state_d;
    mdu_op    op_q, op_in;
    logic [XLEN-1:0] acc_hi_q, acc_lo_q, opb_q, src1_q, src2_q, res_q;
    logic [2:0]      cls_q, cls_in;
    logic            neg1_q, neg2_q;
    logic [CNT_W-1:0] cnt_q;

    logic            c_vld_q;
    logic [XLEN-1:0] c_op1_q, c_op2_q, c_hi_q, c_lo_q;
    logic [2:0]      c_cls_q;

    logic            s1, s2, neg1_in, neg2_in, div_in, div0, ovf, mzero, hit, fast, start, last;
    logic [XLEN-1:0] abs1, abs2, fast_hi, fast_lo;
    logic [XLEN-1:0] step_hi, step_lo, corr_hi, corr_lo;
    logic [2*XLEN-1:0] prod_c;
    logic            fin_raw;
    logic [XLEN-1:0] res_raw;

    function automatic logic [XLEN-1:0] pick(mdu_op op, logic [XLEN-1:0] hi, logic [XLEN-1:0] lo);
        return op_sel_hi(op) ? hi : lo;
    endfunction

    // Request decode: magnitudes, signedness class and fast-path detection
    always_comb begin
        op_in   = mdu_op'(s_op_i);
        s1      = op1_signed(op_in);
        s2      = op2_signed(op_in);
        div_in  = op_is_div(op_in);
        neg1_in = s1 & s_operand1_i[XLEN-1];
        neg2_in = s2 & s_operand2_i[XLEN-1];
        abs1    = neg1_in ? -s_operand1_i : s_operand1_i;
        abs2    = neg2_in ? -s_operand2_i : s_operand2_i;
        cls_in  = {div_in, s1, s2};
        div0    = div_in & (s_operand2_i == '0);
        ovf     = div_in & s1 & (s_operand1_i == XMIN) & (s_operand2_i == '1);
        mzero   = ~div_in & ((s_operand1_i == '0) | (s_operand2_i == '0));
        hit     = CACHE_EN & c_vld_q & (s_operand1_i == c_op1_q)
                & (s_operand2_i == c_op2_q) & (cls_in == c_cls_q);
        fast    = div0 | ovf | mzero | hit;
        fast_hi = '0;
        fast_lo = '0;
        if (hit) begin
            fast_hi = c_hi_q;
            fast_lo = c_lo_q;
        end else if (div0) begin
            fast_hi = s_operand1_i;
            fast_lo = '1;
        end else if (ovf) begin
            fast_lo = XMIN;
        end
    end

    assign start = (state_q == MDU_IDLE) & s_compute_i & ~s_flush_i;
    assign last  = (state_q == MDU_CALC) & (cnt_q == CNT_W'(N-1));

    muldiv_step #(.XLEN(XLEN), .BPC(BPC)) u_step (
        .s_div_i (op_is_div(op_q)),
        .s_hi_i  (acc_hi_q),
        .s_lo_i  (acc_lo_q),
        .s_b_i   (opb_q),
        .s_hi_o  (step_hi),
        .s_lo_o  (step_lo)
    );

    // Sign correction of the final step; remainder takes the dividend's sign
    always_comb begin
        prod_c = (neg1_q ^ neg2_q) ? -{step_hi, step_lo} : {step_hi, step_lo};
        if (op_is_div(op_q)) begin
            corr_hi = neg1_q ? -step_hi : step_hi;
            corr_lo = (neg1_q ^ neg2_q) ? -step_lo : step_lo;
        end else begin
            corr_hi = prod_c[2*XLEN-1:XLEN];
            corr_lo = prod_c[XLEN-1:0];
        end
    end

    // State register
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) state_q <= MDU_IDLE;
        else             state_q <= state_d;
    end

    // Next state; flush overrides everything, stall only holds DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            MDU_IDLE: if (start) state_d = fast ? MDU_DONE : MDU_CALC;
            MDU_CALC: if (last) state_d = MDU_DONE;
            MDU_DONE: if (!s_stall_i) state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase
        if (s_flush_i) state_d = MDU_IDLE;
    end

    // Operand latch, iteration datapath and result register
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            op_q     <= OP_MUL;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opb_q    <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            cls_q    <= '0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
        end else if (start) begin
            op_q     <= op_in;
            src1_q   <= s_operand1_i;
            src2_q   <= s_operand2_i;
            cls_q    <= cls_in;
            neg1_q   <= neg1_in;
            neg2_q   <= neg2_in;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= div_in ? abs1 : abs2;
            opb_q    <= div_in ? abs2 : abs1;
            if (fast) res_q <= pick(op_in, fast_hi, fast_lo);
        end else if (state_q == MDU_CALC) begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
            if (last) res_q <= pick(op_q, corr_hi, corr_lo);
            else      cnt_q <= cnt_q + 1'b1;
        end
    end

    // Cache refresh only from a completed, non-flushed iterative op
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            c_vld_q <= 1'b0;
            c_op1_q <= '0;
            c_op2_q <= '0;
            c_cls_q <= '0;
            c_hi_q  <= '0;
            c_lo_q  <= '0;
        end else if (CACHE_EN && last && !s_flush_i) begin
            c_vld_q <= 1'b1;
            c_op1_q <= src1_q;
            c_op2_q <= src2_q;
            c_cls_q <= cls_q;
            c_hi_q  <= corr_hi;
            c_lo_q  <= corr_lo;
        end
    end

    assign fin_raw  = (state_q == MDU_DONE) & ~s_flush_i;
    assign res_raw  = fin_raw ? res_q : '0;
    assign s_busy_o = (state_q != MDU_IDLE);

    see_wires #(.GROUP(SEEGR_CORE_WIRE), .W(XLEN)) u_see_res (
        .s_c_i (res_raw),
        .s_d_o (s_result_o)
    );

    see_wires #(.GROUP(SEEGR_CORE_WIRE), .W(1)) u_see_fin (
        .s_c_i (fin_raw),
        .s_d_o (s_finished_o)
    );

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter (BPC=1 and BPC=4 instances) with an expectation queue.
module tb_muldiv_iter;
    import p_hardisc::*;

    logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0;
    logic        comp1 = 1'b0, comp4 = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0, b = '0;
    logic        fin1, fin4, busy1, busy4;
    logic [31:0] res1, res4;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
        string       tag;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    muldiv_iter #(.XLEN(32), .BPC(1), .CACHE_EN(1)) u_dut1 (
        .s_clk_i(clk), .s_resetn_i(rst_n), .s_stall_i(stall), .s_flush_i(flush),
        .s_compute_i(comp1), .s_op_i(op), .s_operand1_i(a), .s_operand2_i(b),
        .s_finished_o(fin1), .s_result_o(res1), .s_busy_o(busy1)
    );

    muldiv_iter #(.XLEN(32), .BPC(4), .CACHE_EN(1)) u_dut4 (
        .s_clk_i(clk), .s_resetn_i(rst_n), .s_stall_i(stall), .s_flush_i(flush),
        .s_compute_i(comp4), .s_op_i(op), .s_operand1_i(a), .s_operand2_i(b),
        .s_finished_o(fin4), .s_result_o(res4), .s_busy_o(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [31:0] e, input int lat, input string tag);
        exp_t ex;
        ex.res = e;
        ex.lat = lat;
        ex.tag = tag;
        sb.push_back(ex);
    endtask

    // Issue one op at cycle 0, count cycles to s_finished_o, compare with queue head
    task automatic run(input bit sel, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] e, input int lat,
                       input string tag);
        exp_t ex;
        int   cyc;
        bit   got;
        @(posedge clk); #1;
        op = o; a = x; b = y;
        if (sel) comp4 = 1'b1; else comp1 = 1'b1;
        push_exp(e, lat, tag);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 100) begin
            @(posedge clk); #1;
            comp1 = 1'b0; comp4 = 1'b0;
            cyc++;
            got = sel ? fin4 : fin1;
        end
        ex = sb.pop_front();
        chk({ex.tag, "_lat"}, 32'(cyc), 32'(ex.lat));
        chk({ex.tag, "_res"}, sel ? res4 : res1, ex.res);
    endtask

    initial begin
        exp_t ex;
        int   cyc;
        bit   seen;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fin1", {31'd0, fin1}, 32'd0);
        chk("rst_res1", res1, 32'd0);
        chk("rst_busy1", {31'd0, busy1}, 32'd0);
        chk("rst_fin4", {31'd0, fin4}, 32'd0);
        chk("rst_busy4", {31'd0, busy4}, 32'd0);
        rst_n = 1'b1;

        // multiply, normal path
        run(0, OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_7x-3");
        run(0, OP_MULH,   32'hC000_0000, 32'd8,        32'hFFFF_FFFE, 33, "mulh_neg");
        run(0, OP_MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 33, "mulhsu");
        run(0, OP_MUL,    32'd0,        32'd5,         32'd0,         1,  "mul_zero");
        run(1, OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 9,  "mul4_7x-3");
        run(1, OP_MULH,   32'hC000_0000, 32'd8,        32'hFFFF_FFFE, 9,  "mulh4_neg");

        // divide fast paths
        run(0, OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        run(0, OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, "rem_ovf");
        run(0, OP_DIVU, 32'd100,       32'd0,         32'hFFFF_FFFF, 1, "divu_by0");
        run(0, OP_REMU, 32'd100,       32'd0,         32'd100,       1, "remu_by0");

        // divide normal path followed by cache hit on the paired op
        run(0, OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "div_-7/2");
        run(0, OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1,  "rem_-7/2_hit");
        run(0, OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_7/-2");
        run(0, OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         1,  "rem_7/-2_hit");
        run(0, OP_DIVU, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF, 33, "divu_max");
        run(0, OP_REMU, 32'hFFFF_FFFF, 32'd16,        32'd15,        1,  "remu_max_hit");

        // flush mid-CALC: no result, no cache update
        @(posedge clk); #1;
        op = OP_MULHU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; comp1 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            comp1 = 1'b0;
        end
        flush = 1'b1;
        #1;
        chk("flush_fin_c10", {31'd0, fin1}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy_c11", {31'd0, busy1}, 32'd0);
        chk("flush_fin_c11", {31'd0, fin1}, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            seen |= fin1;
        end
        chk("flush_no_result", {31'd0, seen}, 32'd0);
        run(0, OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_rerun");

        // BPC=4 DIVU with stall held across DONE
        @(posedge clk); #1;
        op = OP_DIVU; a = 32'd1000; b = 32'd7; comp4 = 1'b1;
        push_exp(32'd142, 9, "divu4_stall");
        @(posedge clk); #1;
        comp4 = 1'b0;
        stall = 1'b1;
        cyc = 1;
        while (!fin4 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        ex = sb.pop_front();
        chk({ex.tag, "_lat"}, 32'(cyc), 32'(ex.lat));
        chk({ex.tag, "_res0"}, res4, ex.res);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (k == 3) stall = 1'b0;
            chk($sformatf("%s_fin%0d", ex.tag, k), {31'd0, fin4}, 32'd1);
            chk($sformatf("%s_res%0d", ex.tag, k), res4, ex.res);
        end
        @(posedge clk); #1;
        chk("divu4_idle_busy", {31'd0, busy4}, 32'd0);
        chk("divu4_idle_fin", {31'd0, fin4}, 32'd0);
        chk("divu4_idle_res", res4, 32'd0);

        // reset mid-CALC aborts with no late result
        @(posedge clk); #1;
        op = OP_DIVU; a = 32'd1000; b = 32'd3; comp1 = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            comp1 = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy", {31'd0, busy1}, 32'd0);
        chk("rstmid_res", res1, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            seen |= fin1 | busy1;
        end
        chk("rstmid_no_result", {31'd0, seen}, 32'd0);
        run(0, OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
